// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: shared pipeline types for the memory-access stage
//   MemAccessWidth        - access size encoding (reserved code behaves as word)
//   RdCtrl                - {wEnable, rdAddr, isForwardable}
//   WriteBackStagePipeReg - MEM->WB pipe register contents
//   MemAccessState        - data-memory handshake FSM states
package memory_access_stage_pkg;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_RSVD} MemAccessWidth;
  typedef struct packed {
    logic       wEnable;
    logic [4:0] rdAddr;
    logic       isForwardable;
  } RdCtrl;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    RdCtrl       rdCtrl;
  } WriteBackStagePipeReg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} MemAccessState;
endpackage

// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: data-memory req/gnt/rvalid bus
//   master (pipeline stage): drives dmem_req/we/addr/be/wdata, receives gnt/rvalid/rdata
//   slave  (memory):         the mirror image
interface memory_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access_stage_load_aligner.sv
// memory_access_stage_load_aligner: extracts the addressed byte/half from a load word
//   rdata      - raw 32-bit word from data memory
//   offset     - address bits [1:0] selecting the lane
//   width      - access size
//   isUnsigned - zero-extend instead of sign-extend
//   data       - extended 32-bit result (word and reserved sizes pass through)
module memory_access_stage_load_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [31:0]   rdata,
  input  logic [1:0]    offset,
  input  MemAccessWidth width,
  input  logic          isUnsigned,
  output logic [31:0]   data
);
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  assign byteLane = rdata[{offset, 3'b000} +: 8];
  assign halfLane = offset[1] ? rdata[31:16] : rdata[15:0];
  assign data = width == MEM_BYTE ? {{24{byteLane[7] & ~isUnsigned}}, byteLane}
              : width == MEM_HALF ? {{16{halfLane[15] & ~isUnsigned}}, halfLane}
              : rdata;
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage - data-memory access, load extraction, WB pipe register
//   clk, rst            - falling-edge pipeline clock, asynchronous active-low reset
//   ex_*                - registered execute-stage result for the instruction in MEM
//   dmem                - data-memory bus (req/gnt/rvalid), master side
//   mem_stall           - hold upstream registers while an access is outstanding
//   mem_bypass_data     - forwarding path (ALU result)
//   wb_pc/data/rd_ctrl  - write-back pipe register
//   misalign_exc/addr   - misaligned-access trap pulse and faulting address
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module memory_access_stage
  import memory_access_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ex_pc,
  input  logic [31:0]           ex_alu_result,
  input  logic [31:0]           ex_wdata,
  input  MemAccessWidth         ex_width,
  input  RdCtrl                 ex_rd_ctrl,
  input  logic                  ex_is_load,
  input  logic                  ex_is_store,
  input  logic                  ex_is_load_unsigned,
  memory_access_stage_if.master dmem,
  output logic                  mem_stall,
  output logic [31:0]           mem_bypass_data,
  output logic [31:0]           wb_pc,
  output logic [31:0]           wb_data,
  output RdCtrl                 wb_rd_ctrl,
  output logic                  misalign_exc,
  output logic [31:0]           misalign_addr
);
  MemAccessState        state;
  WriteBackStagePipeReg wbReg;
  logic                 access, misaligned, req, done;
  logic [1:0]           offset;
  logic [3:0]           storeBe;
  logic [31:0]          storeData, loadData;
  assign access = ex_is_load | ex_is_store;
  assign offset = ex_alu_result[1:0];
`ifdef MISALIGN_TRAP_EN
  assign misaligned = access & (ex_width == MEM_HALF ? offset[0] : (ex_width != MEM_BYTE) & (offset != 2'b00));
`else
  assign misaligned = 1'b0;
`endif
  // rst gates the request so nothing reaches memory while the stage is held in reset
  assign req       = rst & access & ~misaligned & (state != WAIT_RESP);
  assign done      = misaligned | ((state == WAIT_RESP) & dmem.dmem_rvalid) | (req & dmem.dmem_gnt & ex_is_store);
  assign mem_stall = rst & access & ~done;
  assign storeBe = ex_width == MEM_BYTE ? 4'b0001 << offset
                 : ex_width == MEM_HALF ? (offset[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;
  assign storeData = ex_width == MEM_BYTE ? {4{ex_wdata[7:0]}}
                   : ex_width == MEM_HALF ? {2{ex_wdata[15:0]}}
                   : ex_wdata;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = ex_is_store;
  assign dmem.dmem_addr  = {ex_alu_result[31:2], 2'b00};
  assign dmem.dmem_be    = (req & ex_is_store) ? storeBe : 4'b0000;
  assign dmem.dmem_wdata = storeData;
  assign mem_bypass_data = ex_alu_result;
  memory_access_stage_load_aligner loadAligner (
    .rdata      (dmem.dmem_rdata),
    .offset     (offset),
    .width      (ex_width),
    .isUnsigned (ex_is_load_unsigned),
    .data       (loadData)
  );
  // Stalled cycles, stores and trapped accesses all register a bubble (wEnable=0)
  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wbReg <= '0;
    end else begin
      state <= state == WAIT_RESP ? (dmem.dmem_rvalid ? IDLE : WAIT_RESP)
             : !req ? IDLE
             : !dmem.dmem_gnt ? WAIT_GNT
             : ex_is_load ? WAIT_RESP : IDLE;
      wbReg.pc                   <= ex_pc;
      wbReg.data                 <= ex_is_load ? loadData : ex_alu_result;
      wbReg.rdCtrl.wEnable       <= ex_rd_ctrl.wEnable & ~mem_stall & ~ex_is_store & ~misaligned;
      wbReg.rdCtrl.rdAddr        <= ex_rd_ctrl.rdAddr;
      wbReg.rdCtrl.isForwardable <= ex_rd_ctrl.isForwardable;
    end
  assign wb_pc      = wbReg.pc;
  assign wb_data    = wbReg.data;
  assign wb_rd_ctrl = wbReg.rdCtrl;
`ifdef MISALIGN_TRAP_EN
  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc  <= misaligned;
      misalign_addr <= misaligned ? ex_alu_result : misalign_addr;
    end
`else
  assign misalign_exc  = 1'b0;
  assign misalign_addr = '0;
`endif
endmodule
